// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between
// NUM_REQ byte requesters, each carrying its own 2-bit baud code.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid/data/baud   per-requester byte handshake, data and baud code
//   req_ready             one-hot single-cycle accept pulse (GRANT state)
//   tx_data, tx_baud      byte and baud code presented to the Tx datapath
//   tx_start              single-cycle frame start pulse
//   tx_busy, tx_done      transmitter mid-frame flag and end-of-frame pulse
//   grant_id              index of the current/last granted requester
//   arb_busy              high whenever the arbiter is not idle
//   timeout               single-cycle watchdog pulse
//
// Build option: define UART_TX_ARB_TIMEOUT_EN to add the START/WAIT
// watchdog (TIMEOUT_CYCLES). Without it, timeout is tied low and the
// arbiter waits on the transmitter indefinitely.

module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 4
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 250000
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [2*NUM_REQ-1:0] req_baud,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic [1:0]           tx_baud,
    output logic                 tx_start,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [2:0]           grant_id,
    output logic                 arb_busy,
    output logic                 timeout
);

    localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SETTLE,
        START,
        WAIT
    } state_e;

    state_e        state_q;
    logic [IW-1:0] rr_q;
    logic [IW-1:0] rr_d;
    logic [SW-1:0] set_q;
    logic [7:0]    data_q;
    logic [1:0]    baud_q;
    logic [2:0]    gid_q;
    logic          timeout_q;

    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;
    logic [7:0]    win_data;
    logic [1:0]    win_baud;
    logic          to_hit;

    // First valid requester searching upward from rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(rr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign win_data = req_data[int'(win)*8 +: 8];
    assign win_baud = req_baud[int'(win)*2 +: 2];
    assign rr_d     = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [17:0] TO_LAST = 18'(TIMEOUT_CYCLES - 1);

    logic [17:0] to_q;

    assign to_hit = (to_q == TO_LAST);
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            set_q     <= '0;
            data_q    <= '0;
            baud_q    <= 2'b00;
            gid_q     <= '0;
            timeout_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            to_q      <= '0;
`endif
        end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
            // Counter only survives while the state holds in START/WAIT.
            timeout_q <= 1'b0;
            to_q      <= '0;
            if ((state_q == START && tx_busy) ||
                (state_q == WAIT && !tx_done)) begin
                if (to_hit) begin
                    timeout_q <= 1'b1;
                end else begin
                    to_q <= to_q + 1'b1;
                end
            end
`endif
            unique case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (found) begin
                        data_q <= win_data;
                        gid_q  <= 3'(win);
                        rr_q   <= rr_d;
                        if (win_baud != baud_q) begin
                            baud_q  <= win_baud;
                            set_q   <= '0;
                            state_q <= SETTLE;
                        end else begin
                            state_q <= START;
                        end
                    end else begin
                        // Requester withdrew before accept.
                        state_q <= IDLE;
                    end
                end
                SETTLE: begin
                    if (set_q == SET_LAST) begin
                        state_q <= START;
                    end else begin
                        set_q <= set_q + 1'b1;
                    end
                end
                START: begin
                    if (!tx_busy) begin
                        state_q <= WAIT;
                    end else if (to_hit) begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (tx_done || to_hit) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Accept pulse and frame start must land in the GRANT/START cycle
    // itself; reset masks them so nothing fires on the reset edge.
    always_comb begin
        req_ready = '0;
        if (state_q == GRANT && found && !reset) begin
            req_ready[win] = 1'b1;
        end
    end

    assign tx_start = (state_q == START) && !tx_busy && !reset;
    assign tx_data  = data_q;
    assign tx_baud  = baud_q;
    assign grant_id = gid_q;
    assign arb_busy = (state_q != IDLE);
    assign timeout  = timeout_q;

endmodule
